// File: rtl/clkdiv_pkg.sv
// Shared types and defaults for the multi-channel clock-enable divider.
package clkdiv_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    PEND = 1'b1
  } cfg_state_t;

  localparam int DEF_NUM_CH   = 2;
  localparam int DEF_CNT_W    = 25;
  localparam int DEF_HALF_CYC = 27000;

  // Channel-select width; a single channel still needs one select bit.
  function automatic int ch_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/clkdiv_channel.sv
// One divider channel: half-period counter, square output and rising-edge tick.
module clkdiv_channel #(
  parameter int CNT_W    = 25,
  parameter int DEF_HALF = 27000
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_half_i,
  output logic             term_o,
  output logic             sq_o,
  output logic             tick_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] half_q, half_d;
  logic             sq_q, sq_d;
  logic             tick_q, tick_d;

  assign term_o = en_i && (cnt_q == half_q - CNT_W'(1));

  // A load at terminal count still toggles with the old half; the new one
  // only governs the following half-period because cnt restarts from 0.
  always_comb begin
    cnt_d  = cnt_q + CNT_W'(1);
    sq_d   = sq_q;
    tick_d = 1'b0;
    half_d = load_i ? load_half_i : half_q;
    if (!en_i) begin
      cnt_d = '0;
      sq_d  = 1'b0;
    end else if (term_o) begin
      cnt_d  = '0;
      sq_d   = ~sq_q;
      tick_d = ~sq_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q  <= '0;
      half_q <= CNT_W'(DEF_HALF);
      sq_q   <= 1'b0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      half_q <= half_d;
      sq_q   <= sq_d;
      tick_q <= tick_d;
    end
  end

  assign sq_o   = sq_q;
  assign tick_o = tick_q;

endmodule

// File: rtl/clk_div_multi.sv
// Multi-channel programmable clock-enable divider with a single-slot
// valid/ready reconfiguration path that only retunes a channel at a safe point.
module clk_div_multi
  import clkdiv_pkg::*;
#(
  parameter int  NUM_CH   = DEF_NUM_CH,
  parameter int  CNT_W    = DEF_CNT_W,
  parameter int  DEF_HALF = DEF_HALF_CYC,
  localparam int CH_W     = ch_width(NUM_CH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] en,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [CNT_W-1:0]  cfg_half,
  output logic              cfg_err,
  output logic [NUM_CH-1:0] sq,
  output logic [NUM_CH-1:0] tick
);

  cfg_state_t        state_q;
  logic              ready_q;
  logic              err_q;
  logic [CH_W-1:0]   pend_ch_q;
  logic [CNT_W-1:0]  pend_half_q;
  logic [NUM_CH-1:0] term;
  logic [NUM_CH-1:0] load;
  logic              req_bad;
  logic              apply;

  assign req_bad = (cfg_half == '0) || (32'(cfg_ch) >= NUM_CH);
  assign apply   = |load;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    // Safe points: the channel's own terminal count, or the channel being idle.
    assign load[i] = (state_q == PEND) && (pend_ch_q == CH_W'(i)) && (term[i] || !en[i]);

    clkdiv_channel #(
      .CNT_W    (CNT_W),
      .DEF_HALF (DEF_HALF)
    ) u_ch (
      .clk_i       (clk),
      .rst_i       (rst),
      .en_i        (en[i]),
      .load_i      (load[i]),
      .load_half_i (pend_half_q),
      .term_o      (term[i]),
      .sq_o        (sq[i]),
      .tick_o      (tick[i])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      ready_q     <= 1'b0;
      err_q       <= 1'b0;
      pend_ch_q   <= '0;
      pend_half_q <= '0;
    end else begin
      err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          ready_q <= 1'b1;
          if (cfg_valid && ready_q) begin
            if (req_bad) begin
              err_q <= 1'b1;
            end else begin
              pend_ch_q   <= cfg_ch;
              pend_half_q <= cfg_half;
              ready_q     <= 1'b0;
              state_q     <= PEND;
            end
          end
        end
        PEND: begin
          if (apply) begin
            ready_q <= 1'b1;
            state_q <= IDLE;
          end
        end
        default: begin
          ready_q <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign cfg_ready = ready_q;
  assign cfg_err   = err_q;

endmodule

// File: tb/tb_clk_div_multi.sv
// Directed bench for clk_div_multi with DEF_HALF=4, NUM_CH=2.
module tb_clk_div_multi;

  localparam int NUM_CH   = 2;
  localparam int CNT_W    = 25;
  localparam int DEF_HALF = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NUM_CH-1:0] en = '0;
  logic              cfg_valid = 1'b0;
  logic              cfg_ready;
  logic [0:0]        cfg_ch = '0;
  logic [CNT_W-1:0]  cfg_half = '0;
  logic              cfg_err;
  logic [NUM_CH-1:0] sq;
  logic [NUM_CH-1:0] tick;

  int n_vec = 0;
  int n_bad = 0;

  clk_div_multi #(
    .NUM_CH   (NUM_CH),
    .CNT_W    (CNT_W),
    .DEF_HALF (DEF_HALF)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_ch    (cfg_ch),
    .cfg_half  (cfg_half),
    .cfg_err   (cfg_err),
    .sq        (sq),
    .tick      (tick)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] en;
    logic       exp_sq0;
    logic       exp_tick0;
    logic       exp_sq1;
  } vec_t;

  vec_t tbl[16];

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic wait_ready(input string name);
    int k = 0;
    while (cfg_ready !== 1'b1 && k < 30) begin
      cyc();
      k++;
    end
    chk(name, 32'(cfg_ready), 32'd1);
  endtask

  // From the next tick on the channel, measure tick-to-tick distance and sq high time.
  task automatic measure(input int ch, output int period, output int high);
    int k = 0;
    period = -1;
    high   = -1;
    while (tick[ch] !== 1'b1 && k < 40) begin
      cyc();
      k++;
    end
    if (k < 40) begin
      period = 0;
      high   = 0;
      do begin
        if (sq[ch] === 1'b1) high++;
        cyc();
        period++;
      end while (tick[ch] !== 1'b1 && period < 40);
    end
  endtask

  task automatic request(input logic [0:0] ch, input int half);
    cfg_valid = 1'b1;
    cfg_ch    = ch;
    cfg_half  = CNT_W'(half);
    cyc();
    cfg_valid = 1'b0;
  endtask

  initial begin
    logic [15:0] sq_pat;
    logic [15:0] tick_pat;
    int per;
    int hi;
    int k;

    sq_pat   = 16'hF0F0;
    tick_pat = 16'h1010;
    for (int c = 0; c < 16; c++) begin
      tbl[c].en        = 2'b01;
      tbl[c].exp_sq0   = sq_pat[c];
      tbl[c].exp_tick0 = tick_pat[c];
      tbl[c].exp_sq1   = 1'b0;
    end

    rst = 1'b1;
    en  = 2'b00;
    cyc();
    cyc();
    chk("rst_sq", 32'(sq), 32'd0);
    chk("rst_tick", 32'(tick), 32'd0);
    chk("rst_ready", 32'(cfg_ready), 32'd0);
    chk("rst_err", 32'(cfg_err), 32'd0);

    // Free-running channel 0 from reset defaults
    rst = 1'b0;
    for (int c = 0; c < 16; c++) begin
      en = tbl[c].en;
      chk($sformatf("t1_sq0_c%0d", c), 32'(sq[0]), 32'(tbl[c].exp_sq0));
      chk($sformatf("t1_tick0_c%0d", c), 32'(tick[0]), 32'(tbl[c].exp_tick0));
      chk($sformatf("t1_sq1_c%0d", c), 32'(sq[1]), 32'(tbl[c].exp_sq1));
      if (c >= 2) chk($sformatf("t1_ready_c%0d", c), 32'(cfg_ready), 32'd1);
      cyc();
    end

    // Rejected requests
    request(1'b0, 0);
    chk("t3_err_pulse", 32'(cfg_err), 32'd1);
    chk("t3_ready_kept", 32'(cfg_ready), 32'd1);
    cyc();
    chk("t3_err_clear", 32'(cfg_err), 32'd0);
    request(1'b1, 0);
    chk("t3_err_pulse_ch1", 32'(cfg_err), 32'd1);
    cyc();
    chk("t3_err_clear_ch1", 32'(cfg_err), 32'd0);
    measure(0, per, hi);
    chk("t3_period0", 32'(per), 32'd8);
    chk("t3_high0", 32'(hi), 32'd4);

    // Retune running channel 0 to half=2
    chk("t2_ready_pre", 32'(cfg_ready), 32'd1);
    request(1'b0, 2);
    chk("t2_ready_pend", 32'(cfg_ready), 32'd0);
    wait_ready("t2_ready_back");
    measure(0, per, hi);
    chk("t2_period0", 32'(per), 32'd4);
    chk("t2_high0", 32'(hi), 32'd2);
    chk("t2_ready_idle", 32'(cfg_ready), 32'd1);

    // Disabled channel 1 picks up half=3 immediately
    request(1'b1, 3);
    chk("t4_ready_pend", 32'(cfg_ready), 32'd0);
    cyc();
    chk("t4_ready_back", 32'(cfg_ready), 32'd1);
    en = 2'b11;
    for (int c = 0; c < 3; c++) begin
      chk($sformatf("t4_sq1_low_c%0d", c), 32'(sq[1]), 32'd0);
      cyc();
    end
    chk("t4_sq1_rise", 32'(sq[1]), 32'd1);
    chk("t4_tick1_rise", 32'(tick[1]), 32'd1);
    measure(1, per, hi);
    chk("t4_period1", 32'(per), 32'd6);
    chk("t4_high1", 32'(hi), 32'd3);

    // Reset while a request is pending
    request(1'b0, 6);
    chk("t5_ready_pend", 32'(cfg_ready), 32'd0);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("t5_ready_rst", 32'(cfg_ready), 32'd0);
    chk("t5_sq_rst", 32'(sq), 32'd0);
    cyc();
    cyc();
    chk("t5_ready_after", 32'(cfg_ready), 32'd1);
    measure(0, per, hi);
    chk("t5_period0", 32'(per), 32'd8);
    measure(1, per, hi);
    chk("t5_period1", 32'(per), 32'd8);

    // half=1: toggle every cycle, tick every second cycle
    request(1'b0, 1);
    wait_ready("t6_ready_back");
    k = 0;
    while (tick[0] !== 1'b1 && k < 20) begin
      cyc();
      k++;
    end
    for (int c = 0; c < 6; c++) begin
      chk($sformatf("t6_sq0_c%0d", c), 32'(sq[0]), 32'((c % 2) == 0));
      chk($sformatf("t6_tick0_c%0d", c), 32'(tick[0]), 32'((c % 2) == 0));
      cyc();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
